// File: rtl/register_file_pkg.sv
// Shared constants and address-width helpers for the register_file bank.
// Optional same-cycle write forwarding is controlled by REGISTER_FILE_WRITE_BYPASS_EN (see read port).
package register_file_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_DEPTH = 8;

   function automatic int clog2(input int value);
      int result;
      int span;
      result = 0;
      span   = 1;
      while (span < value) begin
         span   = span * 2;
         result = result + 1;
      end
      return result;
   endfunction

   // A depth of 1 or 2 still needs one address bit.
   function automatic int addr_width(input int depth);
      return (clog2(depth) < 1) ? 1 : clog2(depth);
   endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One registered read port: range check, zero-register masking, optional write bypass.
// Macro REGISTER_FILE_WRITE_BYPASS_EN forwards a same-cycle valid write into the output.
module register_file_read_port
   import register_file_pkg::*;
#(
   parameter  int WIDTH      = DEFAULT_WIDTH,
   parameter  int DEPTH      = DEFAULT_DEPTH,
   parameter  int ZERO_REG   = 0,
   localparam int ADDR_WIDTH = addr_width(DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [WIDTH-1:0]      regs [DEPTH],
   input  logic                  write_hit,
   input  logic [ADDR_WIDTH-1:0] write_address,
   input  logic [WIDTH-1:0]      write_data,
   input  logic [ADDR_WIDTH-1:0] read_address,
   output logic [WIDTH-1:0]      read_data
);

`ifdef REGISTER_FILE_WRITE_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   logic             in_range;
   logic             is_zero_reg;
   logic             bypass_hit;
   logic [WIDTH-1:0] read_value;
   logic [WIDTH-1:0] read_data_d;
   logic [WIDTH-1:0] read_data_q;

   assign in_range    = ({1'b0, read_address} < DEPTH_W);
   assign is_zero_reg = (ZERO_REG != 0) && (read_address == '0);
   // write_hit already excludes ignored writes, so forwarding can never leak them.
   assign bypass_hit  = BYPASS_EN && write_hit && (write_address == read_address);

   always_comb begin
      read_value = '0;
      if (in_range && !is_zero_reg) begin
         read_value = regs[read_address];
      end
      if (bypass_hit) begin
         read_value = write_data;
      end
      read_data_d = enable ? read_value : read_data_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         read_data_q <= '0;
      end else begin
         read_data_q <= read_data_d;
      end
   end

   assign read_data = read_data_q;

endmodule

// File: rtl/register_file.sv
// DEPTH x WIDTH register bank with one write port and two registered read ports.
// Define REGISTER_FILE_WRITE_BYPASS_EN to return same-cycle writes on the read ports.
module register_file
   import register_file_pkg::*;
#(
   parameter  int               WIDTH       = DEFAULT_WIDTH,
   parameter  int               DEPTH       = DEFAULT_DEPTH,
   parameter  logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter  int               ZERO_REG    = 0,
   localparam int               ADDR_WIDTH  = addr_width(DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_address,
   input  logic [WIDTH-1:0]      write_data,
   input  logic [ADDR_WIDTH-1:0] read_address_a,
   output logic [WIDTH-1:0]      read_data_a,
   input  logic [ADDR_WIDTH-1:0] read_address_b,
   output logic [WIDTH-1:0]      read_data_b
);

   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   // No handshake: every enabled cycle writes (if requested) and updates both read outputs.
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [WIDTH-1:0] regs_q [DEPTH];
   logic             write_in_range;
   logic             write_to_zero;
   logic             write_hit;

   assign write_in_range = ({1'b0, write_address} < DEPTH_W);
   assign write_to_zero  = (ZERO_REG != 0) && (write_address == '0);
   assign write_hit      = enable && write_enable && write_in_range && !write_to_zero;

   always_comb begin
      regs_d = regs_q;
      if (write_hit) begin
         regs_d[write_address] = write_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= ((ZERO_REG != 0) && (i == 0)) ? '0 : RESET_VALUE;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   register_file_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
   ) u_port_a (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .regs          (regs_q),
      .write_hit     (write_hit),
      .write_address (write_address),
      .write_data    (write_data),
      .read_address  (read_address_a),
      .read_data     (read_data_a)
   );

   register_file_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
   ) u_port_b (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .regs          (regs_q),
      .write_hit     (write_hit),
      .write_address (write_address),
      .write_data    (write_data),
      .read_address  (read_address_b),
      .read_data     (read_data_b)
   );

endmodule
